// File: rtl/fg_pkg.sv
// fg_pkg: shared DAC sequencer state type and default write-phase timing
package fg_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} dac_state_t;
  localparam int WR_SETUP_DEF = 1;
  localparam int WR_LOW_DEF = 2;
  localparam int WR_HOLD_DEF = 1;
endpackage

// File: rtl/fg_sync_edge.sv
// fg_sync_edge: multi-flop synchroniser with a registered rising-edge pulse
module fg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk)
    if (!rst_n) begin
      sr <= '0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
      rise <= sr[STAGES-1] & ~prev;
    end
endmodule

// File: rtl/fg_cfg_dac_ctrl.sv
// fg_cfg_dac_ctrl: async-written shadow/active config bank and parallel DAC write sequencer
module fg_cfg_dac_ctrl import fg_pkg::*; #(
  parameter int NUM_REGS = 8,
  parameter int REG_W = 8,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WR_SETUP = WR_SETUP_DEF,
  parameter int WR_LOW = WR_LOW_DEF,
  parameter int WR_HOLD = WR_HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_W-1:0]          cfg_data_i,
  input  logic [ADDR_W-1:0]         cfg_addr_i,
  input  logic                      cfg_wr_async_i,
  output logic [NUM_REGS*REG_W-1:0] cfg_bus_o,
  output logic                      cfg_update_o,
  input  logic [DATA_W-1:0]         sample_i,
  input  logic                      sample_valid_i,
  output logic [DATA_W-1:0]         dac_data_o,
  output logic                      dac_wr_n_o,
  output logic                      dac_clr_n_o,
  output logic                      dac_pd_n_o,
  output logic                      busy_o,
  output logic                      overflow_o
);
  logic wr, commit;
  logic [REG_W-1:0] shadow [NUM_REGS];
  logic [REG_W-1:0] active [NUM_REGS];
  dac_state_t state, state_n;
  logic [15:0] cnt;
  logic last, take, load, wr_n_d;
  logic [DATA_W-1:0] pend, load_d;
  logic pend_v;

  fg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cfg_wr_async_i),
    .rise (wr)
  );

  // the last-register write arms a commit so all shadows land in active together
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      commit <= 1'b0;
      cfg_update_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wr && int'(cfg_addr_i) == i) shadow[i] <= cfg_data_i;
      commit <= wr && int'(cfg_addr_i) == NUM_REGS - 1;
      cfg_update_o <= commit;
      if (commit) active <= shadow;
    end

  for (genvar g = 0; g < NUM_REGS; g++)
    assign cfg_bus_o[(NUM_REGS-1-g)*REG_W +: REG_W] = active[g];

  assign last = cnt == 16'(state == SETUP ? WR_SETUP - 1 : state == STROBE ? WR_LOW - 1 : WR_HOLD - 1);
  assign take = state == HOLD && last;
  assign busy_o = state != IDLE;

  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? '0 : cnt + 1'b1;
    end

  always_comb
    case (state)
      IDLE:    state_n = sample_valid_i ? SETUP : IDLE;
      SETUP:   state_n = last ? STROBE : SETUP;
      STROBE:  state_n = last ? HOLD : STROBE;
      default: state_n = last ? (pend_v || sample_valid_i ? SETUP : IDLE) : HOLD;
    endcase

  always_comb begin
    wr_n_d = state_n != STROBE;
    load = state == IDLE ? sample_valid_i : take && (pend_v || sample_valid_i);
    load_d = take && pend_v ? pend : sample_i;
  end

  // a sample arriving on the final HOLD cycle refills the slot freed by the pending hand-off
  always_ff @(posedge clk)
    if (!rst_n) begin
      dac_data_o <= '0;
      dac_wr_n_o <= 1'b1;
      dac_clr_n_o <= 1'b0;
      dac_pd_n_o <= 1'b0;
      pend <= '0;
      pend_v <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      dac_wr_n_o <= wr_n_d;
      dac_clr_n_o <= 1'b1;
      dac_pd_n_o <= 1'b1;
      if (load) dac_data_o <= load_d;
      if (take) begin
        pend_v <= pend_v && sample_valid_i;
        if (sample_valid_i) pend <= sample_i;
      end else if (busy_o && sample_valid_i) begin
        pend <= sample_i;
        pend_v <= 1'b1;
        overflow_o <= overflow_o | pend_v;
      end
    end
endmodule

// File: tb/tb_fg_cfg_dac_ctrl.sv
// tb_fg_cfg_dac_ctrl: directed stimulus checked against a schedule-based behavioural model
module tb_fg_cfg_dac_ctrl;
  localparam int N = 8, RW = 8, AW = 4, DW = 8, SS = 2;
  localparam int S = fg_pkg::WR_SETUP_DEF, L = fg_pkg::WR_LOW_DEF, H = fg_pkg::WR_HOLD_DEF;
  localparam int P = S + L + H;

  logic clk = 0, rst_n = 0;
  logic [RW-1:0] cfg_data_i = '0;
  logic [AW-1:0] cfg_addr_i = '0;
  logic cfg_wr_async_i = 0;
  logic [N*RW-1:0] cfg_bus_o;
  logic cfg_update_o;
  logic [DW-1:0] sample_i = '0;
  logic sample_valid_i = 0;
  logic [DW-1:0] dac_data_o;
  logic dac_wr_n_o, dac_clr_n_o, dac_pd_n_o, busy_o, overflow_o;

  fg_cfg_dac_ctrl #(
    .NUM_REGS(N), .REG_W(RW), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS),
    .WR_SETUP(S), .WR_LOW(L), .WR_HOLD(H)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i), .cfg_wr_async_i(cfg_wr_async_i),
    .cfg_bus_o(cfg_bus_o), .cfg_update_o(cfg_update_o),
    .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .dac_data_o(dac_data_o), .dac_wr_n_o(dac_wr_n_o), .dac_clr_n_o(dac_clr_n_o),
    .dac_pd_n_o(dac_pd_n_o), .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: a write lands SS+1 edges after the strobe is first seen; a sequence is a P-cycle window
  logic [RW-1:0] m_sh [N];
  logic [RW-1:0] m_act [N];
  logic m_upd, m_wrp, m_on, m_pv, m_ovf, m_ctl;
  int wr_at, cm_at, start, ph;
  logic [DW-1:0] m_cur, m_pend;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      foreach (m_sh[i]) begin
        m_sh[i] = '0;
        m_act[i] = '0;
      end
      m_upd = 0; m_wrp = 0; m_on = 0; m_pv = 0; m_ovf = 0; m_ctl = 0;
      wr_at = -1; cm_at = -1; start = 0; m_cur = '0; m_pend = '0;
    end else begin
      m_ctl = 1;
      m_upd = 0;
      if (cm_at == cyc) begin
        m_act = m_sh;
        m_upd = 1;
      end
      if (wr_at == cyc) begin
        for (int i = 0; i < N; i++) if (int'(cfg_addr_i) == i) m_sh[i] = cfg_data_i;
        if (int'(cfg_addr_i) == N - 1) cm_at = cyc + 1;
      end
      if (cfg_wr_async_i && !m_wrp) wr_at = cyc + SS + 1;
      m_wrp = cfg_wr_async_i;
      ph = cyc - 1 - start;
      if (!(m_on && ph < P)) begin
        if (sample_valid_i) begin
          m_on = 1; start = cyc; m_cur = sample_i;
        end
      end else if (ph == P - 1) begin
        if (m_pv) begin
          start = cyc; m_cur = m_pend; m_pv = sample_valid_i; m_pend = sample_i;
        end else if (sample_valid_i) begin
          start = cyc; m_cur = sample_i;
        end
      end else if (sample_valid_i) begin
        m_ovf = m_ovf | m_pv; m_pv = 1; m_pend = sample_i;
      end
    end
  end

  logic [N*RW-1:0] e_bus;
  logic prev_wrn = 1;
  int upd_cnt = 0, upd_cyc = 0;
  logic [DW-1:0] strobes [$];

  always @(posedge clk) begin
    int q;
    #1;
    q = cyc - start;
    for (int i = 0; i < N; i++) e_bus[(N-1-i)*RW +: RW] = m_act[i];
    check("cfg_bus", cfg_bus_o, e_bus);
    check("cfg_update", cfg_update_o, m_upd);
    check("dac_data", dac_data_o, m_cur);
    check("busy", busy_o, m_on && q < P);
    check("dac_wr_n", dac_wr_n_o, !(m_on && q >= S && q < S + L));
    check("overflow", overflow_o, m_ovf);
    check("dac_clr_pd", {dac_clr_n_o, dac_pd_n_o}, {m_ctl, m_ctl});
    if (cfg_update_o) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
    if (prev_wrn && !dac_wr_n_o) strobes.push_back(dac_data_o);
    prev_wrn = dac_wr_n_o;
  end

  task automatic host_wr(input int a, input int d, input int len, output int t0);
    @(negedge clk);
    cfg_addr_i = AW'(a);
    cfg_data_i = RW'(d);
    cfg_wr_async_i = 1;
    t0 = cyc;
    repeat (len) @(negedge clk);
    cfg_wr_async_i = 0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int t0;
    logic [DW-1:0] s0, s1;
    repeat (3) @(negedge clk);
    check("rst_bus", cfg_bus_o, 0);
    check("rst_wr_n", dac_wr_n_o, 1);
    check("rst_clr_pd", {dac_clr_n_o, dac_pd_n_o}, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1;
    @(negedge clk);
    check("clr_pd_release", {dac_clr_n_o, dac_pd_n_o}, 2'b11);

    host_wr(2, 'h5A, 8, t0);
    check("addr2_bus_unchanged", cfg_bus_o, 0);
    check("addr2_no_pulse", upd_cnt, 0);
    host_wr(7, 'h11, 8, t0);
    check("commit_reg2", cfg_bus_o[47:40], 'h5A);
    check("commit_reg7", cfg_bus_o[7:0], 'h11);
    check("commit_pulses", upd_cnt, 1);
    check("commit_latency", upd_cyc - t0, 5);
    host_wr(7, 'h22, 50, t0);
    check("long_strobe_pulses", upd_cnt, 2);
    check("long_strobe_latency", upd_cyc - t0, 5);
    check("long_strobe_reg7", cfg_bus_o[7:0], 'h22);
    host_wr(9, 'hEE, 8, t0);
    check("addr9_no_pulse", upd_cnt, 2);
    host_wr(7, 'h33, 8, t0);
    check("addr9_no_alias", cfg_bus_o, 64'h00005A0000000033);
    check("addr9_then_commit", upd_cnt, 3);

    strobes.delete();
    @(negedge clk); sample_i = 'hA5; sample_valid_i = 1;
    @(negedge clk); sample_valid_i = 0;
    check("a5_data_t1", dac_data_o, 'hA5);
    check("a5_wr_n_t1", dac_wr_n_o, 1);
    @(negedge clk); check("a5_wr_n_t2", dac_wr_n_o, 0);
    @(negedge clk); check("a5_wr_n_t3", dac_wr_n_o, 0);
    @(negedge clk); check("a5_wr_n_t4", dac_wr_n_o, 1); check("a5_busy_t4", busy_o, 1);
    @(negedge clk); check("a5_busy_t5", busy_o, 0);

    repeat (3) @(negedge clk);
    strobes.delete();
    sample_i = 'h10; sample_valid_i = 1;
    @(negedge clk); sample_i = 'h20;
    @(negedge clk); sample_i = 'h30;
    @(negedge clk); sample_valid_i = 0;
    repeat (12) @(negedge clk);
    s0 = strobes.size() > 0 ? strobes[0] : '0;
    s1 = strobes.size() > 1 ? strobes[1] : '0;
    check("ovf_strobe_count", strobes.size(), 2);
    check("ovf_first", s0, 'h10);
    check("ovf_second", s1, 'h30);
    check("ovf_flag", overflow_o, 1);

    @(negedge clk); sample_i = 'h40; sample_valid_i = 1;
    @(negedge clk); sample_valid_i = 0;
    repeat (3) @(negedge clk);
    sample_i = 'h50; sample_valid_i = 1;
    @(negedge clk); sample_valid_i = 0;
    check("hold_chain_busy", busy_o, 1);
    check("hold_chain_data", dac_data_o, 'h50);
    @(negedge clk); check("hold_chain_wr_n", dac_wr_n_o, 0);
    repeat (6) @(negedge clk);

    sample_i = 'h77; sample_valid_i = 1;
    @(negedge clk); sample_valid_i = 0;
    @(negedge clk); check("abort_in_strobe", dac_wr_n_o, 0);
    rst_n = 0;
    @(negedge clk);
    check("abort_wr_n", dac_wr_n_o, 1);
    check("abort_data", dac_data_o, 0);
    rst_n = 1;
    strobes.delete();
    repeat (10) @(negedge clk);
    check("abort_no_strobe", strobes.size(), 0);
    check("abort_idle", busy_o, 0);
    check("abort_ovf_clear", overflow_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
